apb4_master_bridge: RTL and testbench
=====================================

Name: apb4_master_bridge

Overview:
- Converts a single-outstanding valid/ready request/response port, driven by the core load/store unit or a debug/DMA port, into APB4 transfers.
- Its APB4 master signals feed the slave side of the APB4 address-decoding mux, which fans out to peripherals.
- Generates the SETUP and ACCESS phases, honours PREADY wait states, and returns PRDATA/PSLVERR as a registered response.

Parameters:
- ADDR_WIDTH, 32, request/APB address width
- DATA_WIDTH, 32, request/APB data width; must be a multiple of 8
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error; used only with the optional feature; must be >= 2

Ports:
- clk_i  in  1  clock; also used as PCLK
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_addr_i  in  ADDR_WIDTH  byte address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  byte strobes
- req_prot_i  in  3  APB4 protection attributes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- rsp_err_o  out  1  slave error (or timeout)
- paddr_o  out  ADDR_WIDTH  PADDR
- psel_o  out  1  PSEL
- penable_o  out  1  PENABLE
- pwrite_o  out  1  PWRITE
- pwdata_o  out  DATA_WIDTH  PWDATA
- pstrb_o  out  DATA_WIDTH/8  PSTRB
- pprot_o  out  3  PPROT
- prdata_i  in  DATA_WIDTH  PRDATA
- pready_i  in  1  PREADY
- pslverr_i  in  1  PSLVERR

Behaviour:
- Clocking/reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: state = IDLE; all registered outputs 0. This covers psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o, rsp_valid_o, rsp_rdata_o and rsp_err_o.
- req_ready_o is combinational and equals (state == IDLE) only. It has no combinational dependence on any input.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs come from registers.
- IDLE:
  - On req_valid_i & req_ready_o, register addr, write, wdata, prot and strb into the APB output registers, then go to SETUP.
  - Strobe rule: pstrb_o = req_strb_i for writes, forced to 0 for reads (APB4 rule).
  - pwdata_o = captured req_wdata_i for writes, 0 for reads.
- SETUP: psel_o = 1, penable_o = 0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1. paddr/pwrite/pwdata/pstrb/pprot stay stable.
  - pready_i = 0: stay in ACCESS (wait state).
  - pready_i = 1: register rsp_rdata_o = write ? 0 : prdata_i and rsp_err_o = pslverr_i. Drop psel_o and penable_o to 0 the next cycle and go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o held stable.
  - On rsp_ready_i, clear rsp_valid_o the next cycle and go to IDLE.
- Idle bus: psel_o = penable_o = 0. paddr/pwrite/pprot keep the last value; pwdata_o and pstrb_o keep the last value until the next capture.
- Latency with zero-wait-state slave:
  - Request accepted at edge T: SETUP is visible in cycle T+1, ACCESS in cycle T+2.
  - rsp_valid_o rises in cycle T+3. If rsp_ready_i = 1, req_ready_o is high again in cycle T+4.
  - Minimum 4 cycles per transfer; each wait state adds 1.
- Only one transfer is outstanding; there is no pipelining. A new request is never accepted while a response is pending.
- pslverr_i is sampled only in the cycle where ACCESS & pready_i; it is ignored otherwise. pready_i outside ACCESS is ignored.
- Reset mid-operation (any state):
  - Next edge: state IDLE; psel_o = penable_o = rsp_valid_o = 0.
  - The transfer is abandoned with no response.
  - Requester must treat reset as flushing its own state.
- Backpressure: rsp_ready_i = 0 holds RESP indefinitely. The APB bus stays idle meanwhile.

Optional Feature:
- Macro APB4_MASTER_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer terminates as if PREADY had arrived, with rsp_err_o = 1 and rsp_rdata_o = 0. psel_o and penable_o drop next cycle; go to RESP.
  - pready_i = 1 in the same cycle as the limit takes priority: normal completion.
- Undefined: no counter; ACCESS waits for pready_i forever.

Test Plan:
- Write 0xDEADBEEF to 0x4000_0010, strb 0xF, prot 3'b010, zero-wait slave -> SETUP in T+1 with psel=1, penable=0; ACCESS in T+2 with penable=1, pstrb=0xF, pprot=2; rsp_valid in T+3 with rdata=0, err=0.
- Read 0x8000_0004, slave returns 0x1234_5678 after 3 wait states -> ACCESS lasts 4 cycles; pstrb=0 throughout; rsp_rdata=0x1234_5678; rsp_valid at T+6.
- Read with pslverr=1 at the completing cycle, pslverr=1 pulsed earlier during wait states -> only the final sample is used; rsp_err=1.
- Hold rsp_ready_i=0 for 5 cycles with a new req_valid pending -> rsp fields stable, req_ready=0, psel=0; request accepted the cycle after rsp handshake + 1.
- Assert rst_i during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=1; a following write completes normally.
- With APB4_MASTER_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, then rsp_err=1 and rdata=0. Without the macro, the bridge is still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge
// Turns a single-outstanding valid/ready request/response port into APB4
// transfers. Each transfer has one SETUP cycle and then an ACCESS phase that
// lasts until PREADY. PRDATA and PSLVERR are returned as a registered response.
//
// Handshake semantics: a request transfers on the clock edge where
// req_valid_i & req_ready_o are both 1. A response transfers on the edge where
// rsp_valid_o & rsp_ready_i are both 1. Once a valid is raised, it and its
// payload stay stable until the matching ready.
//
// Ports:
//   clk_i, rst_i            clock (also PCLK); synchronous active-high reset
//   req_*                   request channel (addr, write, wdata, strb, prot)
//   rsp_*                   response channel (rdata, err)
//   p*_o / prdata_i,
//   pready_i, pslverr_i     APB4 master signals
//
// Optional build macro: APB4_MASTER_BRIDGE_TIMEOUT_EN
//   When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles without
//   PREADY ends with rsp_err_o = 1 and rsp_rdata_o = 0.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;
  logic   timeout_hit;
  logic   access_done;

`ifdef APB4_MASTER_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Clearing the counter during SETUP means it starts at zero on entry to
  // ACCESS. The limit fires in the cycle in which the count of earlier waited
  // cycles is TIMEOUT_CYCLES-1. That gives exactly TIMEOUT_CYCLES ACCESS cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !pready_i) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready_i &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A real PREADY always wins over a timeout that fires in the same cycle.
  assign access_done = (state == ACCESS) && (pready_i || timeout_hit);
  assign req_ready_o = (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All APB and response outputs are registered. They are updated only on the
  // phase transitions below, so they hold their value in every other cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_o     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      pprot_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            paddr_o  <= req_addr_i;
            pwrite_o <= req_write_i;
            pprot_o  <= req_prot_i;
            // Reads drive no write data and all-zero strobes.
            pwdata_o <= req_write_i ? req_wdata_i : '0;
            pstrb_o  <= req_write_i ? req_strb_i : '0;
            psel_o   <= 1'b1;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (access_done) begin
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            // A timeout (no PREADY) returns an error with zero data.
            rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
            rsp_rdata_o <= (pready_i && !pwrite_o) ? prdata_i : '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed testbench for apb4_master_bridge. Expected responses go into a
// queue when a transfer is issued. A monitor pops the queue and compares it
// on every response handshake. Build with +define+APB4_MASTER_BRIDGE_TIMEOUT_EN
// to exercise the timeout path (TIMEOUT_CYCLES = 4).
module tb_apb4_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {err, rdata}
  logic [32:0] mon_e;

  apb4_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb), .req_prot_i(req_prot),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one compare per response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[31:0]));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e[32]));
      end
    end
  end

  // Driver: a complete transfer with `waits` wait states, rsp_ready held at 1.
  // Junk PREADY/PSLVERR during SETUP and early PSLVERR pulses must be ignored.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] rd, input logic err, input logic early_err,
                      input logic [31:0] exp_pwdata, input logic [3:0] exp_pstrb);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
    req_strb = strb; req_prot = prot; rsp_ready = 1'b1;
    pready = 1'b0; pslverr = 1'b0;
    chk("idle_req_ready", 64'(req_ready), 64'(1));
    tick();  // SETUP cycle
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd;
    chk("setup_psel", 64'(psel), 64'(1));
    chk("setup_penable", 64'(penable), 64'(0));
    chk("setup_paddr", 64'(paddr), 64'(addr));
    chk("setup_pwrite", 64'(pwrite), 64'(wr));
    chk("setup_pwdata", 64'(pwdata), 64'(exp_pwdata));
    chk("setup_pstrb", 64'(pstrb), 64'(exp_pstrb));
    chk("setup_pprot", 64'(pprot), 64'(prot));
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    for (int i = 0; i <= waits; i++) begin
      tick();  // ACCESS cycle
      chk("access_psel", 64'(psel), 64'(1));
      chk("access_penable", 64'(penable), 64'(1));
      chk("access_paddr", 64'(paddr), 64'(addr));
      chk("access_pstrb", 64'(pstrb), 64'(exp_pstrb));
      chk("access_pwdata", 64'(pwdata), 64'(exp_pwdata));
      pready  = (i == waits);
      pslverr = (i == waits) ? err : early_err;
      prdata  = (i == waits) ? rd : ~rd;
    end
    tick();  // RESP cycle
    pready = 1'b0; pslverr = 1'b0;
    chk("resp_valid", 64'(rsp_valid), 64'(1));
    chk("resp_psel", 64'(psel), 64'(0));
    chk("resp_penable", 64'(penable), 64'(0));
    chk("resp_req_ready", 64'(req_ready), 64'(0));
    tick();
    chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_req_ready", 64'(req_ready), 64'(1));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick();
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_pstrb", 64'(pstrb), 64'(0));
    chk("rst_pprot", 64'(pprot), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    rst = 1'b0;
    tick();

    // Zero-wait write: rdata forced to 0 even though PRDATA is non-zero.
    exp_q.push_back({1'b0, 32'h0});
    xfer(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h5A5A_5A5A, 1'b0, 1'b0,
         32'hDEAD_BEEF, 4'hF);
    // Read with 3 wait states: strobes and wdata forced to 0.
    exp_q.push_back({1'b0, 32'h1234_5678});
    xfer(32'h8000_0004, 1'b0, 32'h0000_0055, 4'hF, 3'b000, 3, 32'h1234_5678, 1'b0, 1'b0,
         32'h0, 4'h0);
    // Early PSLVERR pulses and a clean final sample give no error.
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    xfer(32'h8000_0008, 1'b0, 32'h0, 4'hF, 3'b001, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 4'h0);
    // Early PSLVERR pulses and PSLVERR set in the final sample give an error.
    exp_q.push_back({1'b1, 32'h0BAD_BEEF});
    xfer(32'h8000_000C, 1'b0, 32'h0, 4'h0, 3'b101, 2, 32'h0BAD_BEEF, 1'b1, 1'b1, 32'h0, 4'h0);
    // Write with slave error and partial strobes.
    exp_q.push_back({1'b1, 32'h0});
    xfer(32'h4000_0014, 1'b1, 32'hA5A5_A5A5, 4'h6, 3'b111, 1, 32'hFFFF_FFFF, 1'b1, 1'b0,
         32'hA5A5_A5A5, 4'h6);

    // Response backpressure with a new request waiting.
    exp_q.push_back({1'b0, 32'h0BAD_CAFE});
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_write = 1'b0; req_strb = 4'h0; req_prot = 3'b000;
    tick();  // SETUP
    chk("bp_setup_psel", 64'(psel), 64'(1));
    req_addr = 32'h4000_0020; req_write = 1'b1; req_wdata = 32'h1122_3344;
    req_strb = 4'h3; req_prot = 3'b001;
    chk("bp_setup_req_ready", 64'(req_ready), 64'(0));
    tick();  // ACCESS
    pready = 1'b1; prdata = 32'h0BAD_CAFE; pslverr = 1'b0;
    tick();  // RESP
    pready = 1'b0; prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'h0BAD_CAFE));
      chk("bp_rsp_err", 64'(rsp_err), 64'(0));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_psel", 64'(psel), 64'(0));
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    tick();  // IDLE; pending request accepted at the next edge
    chk("bp_idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("bp_idle_req_ready", 64'(req_ready), 64'(1));
    chk("bp_idle_psel", 64'(psel), 64'(0));
    tick();  // SETUP of queued write
    req_valid = 1'b0;
    chk("bp2_psel", 64'(psel), 64'(1));
    chk("bp2_paddr", 64'(paddr), 64'(32'h4000_0020));
    chk("bp2_pwdata", 64'(pwdata), 64'(32'h1122_3344));
    chk("bp2_pstrb", 64'(pstrb), 64'(4'h3));
    chk("bp2_pprot", 64'(pprot), 64'(3'b001));
    pready = 1'b1;
    tick();  // ACCESS
    chk("bp2_penable", 64'(penable), 64'(1));
    tick();  // RESP
    pready = 1'b0;
    chk("bp2_rsp_valid", 64'(rsp_valid), 64'(1));
    tick();

    // Reset during ACCESS abandons the transfer with no response.
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_write = 1'b0; prdata = 32'h7777_7777;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_penable_before", 64'(penable), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_psel", 64'(psel), 64'(0));
    chk("rst_mid_penable", 64'(penable), 64'(0));
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mid_req_ready", 64'(req_ready), 64'(1));
    exp_q.push_back({1'b0, 32'h0});
    xfer(32'h4000_0030, 1'b1, 32'h0F0F_0F0F, 4'h9, 3'b100, 0, 32'h1, 1'b0, 1'b0,
         32'h0F0F_0F0F, 4'h9);

    // Slave that never raises PREADY.
    req_valid = 1'b1; req_addr = 32'h8000_0030; req_write = 1'b0; req_strb = 4'h0;
    prdata = 32'hFFFF_FFFF; pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b1;
`ifdef APB4_MASTER_BRIDGE_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    tick();  // SETUP
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_access_penable", 64'(penable), 64'(1));
      chk("to_access_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    tick();
    chk("to_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("to_psel", 64'(psel), 64'(0));
    tick();
    chk("to_req_ready", 64'(req_ready), 64'(1));
`else
    begin
      int bad;
      bad = 0;
      tick();  // SETUP
      req_valid = 1'b0;
      repeat (100) begin
        tick();
        if (!(psel && penable) || rsp_valid) bad++;
      end
      chk("no_timeout_still_access", 64'(bad), 64'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("no_timeout_rst_psel", 64'(psel), 64'(0));
    end
`endif

    repeat (3) tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
